image_read_ctrl: RTL

IMAGE_READ_CTRL -- requirements
Module: image_read_ctrl

---
 rtl/image_read_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/image_read_ctrl.sv
// Raster-order pixel reader: streams a WIDTH x HEIGHT frame from a 1-cycle-latency
// pixel memory into a 2-entry FIFO with coordinates and frame/line flags attached.
//   state | meaning
//   IDLE  | waiting for start, no reads, FIFO empty
//   RUN   | issuing reads while FIFO occupancy + in-flight read < 2
//   DRAIN | all reads issued, emptying FIFO until the end-of-frame beat leaves
module image_read_ctrl #(
  parameter int WIDTH  = 668,
  parameter int HEIGHT = 452,
  parameter int ADDR_W = 19
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [7:0]        m_data,
  output logic [9:0]        m_x,
  output logic [8:0]        m_y,
  output logic              m_sof,
  output logic              m_eol,
  output logic              m_eof,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);
  localparam logic [9:0]        X_LAST    = 10'(WIDTH - 1);
  localparam logic [8:0]        Y_LAST    = 9'(HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  typedef struct packed {
    logic [7:0] data;
    logic [9:0] x;
    logic [8:0] y;
    logic       sof;
    logic       eol;
    logic       eof;
  } beat_t;

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_raddr;
  logic [9:0]        r_rx, r_if_x;
  logic [8:0]        r_ry, r_if_y;
  logic              r_inflight;
  beat_t             r_fifo [2];
  logic              r_wptr, r_rptr;
  logic [1:0]        r_cnt;
  logic              r_done;
  logic              w_pop, w_push, w_done;
  logic [2:0]        w_budget;
  beat_t             w_head, w_new;

  assign w_head = r_fifo[r_rptr];
  assign w_pop  = (r_cnt != 2'd0) && m_ready;
  assign w_push = r_inflight;
  // Occupancy is taken after this cycle's pop so a full-rate stream never stalls.
  assign w_budget = {1'b0, r_cnt} - {2'b00, w_pop} + {2'b00, r_inflight};

  assign w_new.data = mem_rdata;
  assign w_new.x    = r_if_x;
  assign w_new.y    = r_if_y;
  assign w_new.sof  = (r_if_x == 10'd0) && (r_if_y == 9'd0);
  assign w_new.eol  = (r_if_x == X_LAST);
  assign w_new.eof  = (r_if_x == X_LAST) && (r_if_y == Y_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    mem_rd_en = 1'b0;
    w_done    = 1'b0;
    case (r_state)
      IDLE: if (start && !abort) w_next = RUN;
      RUN: begin
        if (abort) begin
          w_next = IDLE;
        end else begin
          mem_rd_en = (w_budget < 3'd2);
          if (mem_rd_en && (r_raddr == LAST_ADDR)) w_next = DRAIN;
        end
      end
      DRAIN: begin
        if (abort) begin
          w_next = IDLE;
        end else if (w_pop && w_head.eof) begin
          w_next = IDLE;
          w_done = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_raddr    <= '0;
      r_rx       <= '0;
      r_ry       <= '0;
      r_inflight <= 1'b0;
      r_if_x     <= '0;
      r_if_y     <= '0;
      r_done     <= 1'b0;
    end else begin
      r_inflight <= mem_rd_en;
      r_done     <= w_done;
      if (r_state == IDLE) begin
        r_raddr <= '0;
        r_rx    <= '0;
        r_ry    <= '0;
      end else if (mem_rd_en) begin
        r_if_x  <= r_rx;
        r_if_y  <= r_ry;
        r_raddr <= r_raddr + ADDR_W'(1);
        if (r_rx == X_LAST) begin
          r_rx <= '0;
          r_ry <= r_ry + 9'd1;
        end else begin
          r_rx <= r_rx + 10'd1;
        end
      end
    end
  end

  // Abort also drops the read returning this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fifo[0] <= '0;
      r_fifo[1] <= '0;
      r_wptr    <= 1'b0;
      r_rptr    <= 1'b0;
      r_cnt     <= 2'd0;
    end else if ((r_state != IDLE) && abort) begin
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
      r_cnt  <= 2'd0;
    end else begin
      if (w_push) begin
        r_fifo[r_wptr] <= w_new;
        r_wptr         <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign mem_addr = r_raddr;
  assign m_valid  = (r_cnt != 2'd0);
  assign m_data   = w_head.data;
  assign m_x      = w_head.x;
  assign m_y      = w_head.y;
  assign m_sof    = w_head.sof;
  assign m_eol    = w_head.eol;
  assign m_eof    = w_head.eof;
  assign busy     = (r_state != IDLE);
  assign done     = r_done;

endmodule
